elevator_ctrl: RTL and testbench

//  Elevator controller FSM, directly upstream of the 4-digit seven-segment scanner. Latches hall/car

---
 rtl/elevator_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_elevator_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// ----------------------------------------------------------------------------------------------
// elevator_ctrl
//
// Elevator controller feeding a 4-digit seven-segment scanner. Latches hall/car requests, moves
// the car one floor at a time using a SCAN policy (keep going while work remains in the current
// direction), sequences the doors, and encodes status as four display nibbles.
//
// Display nibble codes: 0-9 digits, 10 "U", 11 "d", 12 "-", 13 "p", 14 "C", 15 blank.
//
// Parameters:
//   FLOORS       number of floors (2..9), displayed 1..FLOORS
//   MOVE_TICKS   clock cycles to travel one floor (>= 2)
//   DOOR_TICKS   clock cycles the door stays fully open (>= 2)
//   CLOSE_TICKS  clock cycles of the door-closing phase (>= 2)
//
// Ports:
//   clk190hz   in   system clock
//   rst        in   asynchronous active-high reset
//   req        in   level request per floor, bit i = floor i+1
//   open_btn   in   door-open button, level
//   close_btn  in   door-close button, level
//   dataBus    out  display bus: [3:0] floor, [7:4] direction, [11:8] door, [15:12] target
//   floor      out  current floor index 0..FLOORS-1
//   door_open  out  high while the door is open or closing
//   pending    out  latched outstanding requests
// ----------------------------------------------------------------------------------------------
module elevator_ctrl #(
  parameter int unsigned FLOORS      = 8,
  parameter int unsigned MOVE_TICKS  = 380,
  parameter int unsigned DOOR_TICKS  = 570,
  parameter int unsigned CLOSE_TICKS = 190
) (
  input  logic              clk190hz,
  input  logic              rst,
  input  logic [FLOORS-1:0] req,
  input  logic              open_btn,
  input  logic              close_btn,
  output logic [15:0]       dataBus,
  output logic [3:0]        floor,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);

  // Timer is shared by all timed states, so it is sized for the longest phase.
  localparam int unsigned MaxMd    = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int unsigned MaxTicks = (MaxMd > CLOSE_TICKS) ? MaxMd : CLOSE_TICKS;
  localparam int unsigned TimerW   = $clog2(MaxTicks);

  localparam logic [TimerW-1:0] MoveLast  = TimerW'(MOVE_TICKS - 1);
  localparam logic [TimerW-1:0] DoorLast  = TimerW'(DOOR_TICKS - 1);
  localparam logic [TimerW-1:0] CloseLast = TimerW'(CLOSE_TICKS - 1);
  localparam logic [3:0]        TopFloor  = 4'(FLOORS - 1);

  localparam logic [3:0] NibUp    = 4'd10;
  localparam logic [3:0] NibDown  = 4'd11;
  localparam logic [3:0] NibDash  = 4'd12;
  localparam logic [3:0] NibOpen  = 4'd13;
  localparam logic [3:0] NibClose = 4'd14;
  localparam logic [3:0] NibBlank = 4'd15;

  localparam logic [15:0] BusReset = 16'hFCC1;

  typedef enum logic [2:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen,
    StDoorClose
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          floor_q, floor_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                dir_up_q, dir_up_d;
  logic [FLOORS-1:0]   pending_q, pending_d;
  logic [15:0]         bus_q, bus_d;
  logic                enter_open;
  logic                door_state;

  // Request summary relative to the current floor and to both neighbours (the latter are what
  // a move sees on the cycle it arrives at the next floor).
  logic [FLOORS-1:0]   req_all;
  logic                here;
  logic                above;
  logic                below;
  logic                at_up;
  logic                above_up;
  logic                at_dn;
  logic                below_dn;
  logic                req_here;

  assign door_state = (state_q == StDoorOpen) || (state_q == StDoorClose);

  always_comb begin
    req_all  = pending_q | req;
    here     = 1'b0;
    above    = 1'b0;
    below    = 1'b0;
    at_up    = 1'b0;
    above_up = 1'b0;
    at_dn    = 1'b0;
    below_dn = 1'b0;
    req_here = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (i == int'(floor_q)) begin
        req_here = req[i];
      end
      if (req_all[i]) begin
        if (i == int'(floor_q))     here     = 1'b1;
        if (i >  int'(floor_q))     above    = 1'b1;
        if (i <  int'(floor_q))     below    = 1'b1;
        if (i == int'(floor_q) + 1) at_up    = 1'b1;
        if (i >  int'(floor_q) + 1) above_up = 1'b1;
        if (i == int'(floor_q) - 1) at_dn    = 1'b1;
        if (i <  int'(floor_q) - 1) below_dn = 1'b1;
      end
    end
  end

  // Next-state logic. Timer defaults to zero so any state change restarts it.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    timer_d    = '0;
    dir_up_d   = dir_up_q;
    enter_open = 1'b0;

    case (state_q)
      StIdle: begin
        if (here) begin
          state_d    = StDoorOpen;
          enter_open = 1'b1;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = StMoveUp;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = StMoveDown;
          dir_up_d = 1'b0;
        end
      end

      StMoveUp: begin
        if (floor_q >= TopFloor) begin
          // Cannot go higher; should not happen since a move needs a request above.
          state_d = StIdle;
        end else if (timer_q == MoveLast) begin
          floor_d = floor_q + 4'd1;
          if (at_up) begin
            state_d    = StDoorOpen;
            enter_open = 1'b1;
          end else if (!above_up) begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StMoveDown: begin
        if (floor_q == 4'd0) begin
          state_d = StIdle;
        end else if (timer_q == MoveLast) begin
          floor_d = floor_q - 4'd1;
          if (at_dn) begin
            state_d    = StDoorOpen;
            enter_open = 1'b1;
          end else if (!below_dn) begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StDoorOpen: begin
        // Open button (or a new call at this floor) holds the door; it beats close_btn.
        if (open_btn || req_here) begin
          timer_d = '0;
        end else if (close_btn || (timer_q == DoorLast)) begin
          state_d = StDoorClose;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StDoorClose: begin
        if (open_btn || req_here) begin
          state_d    = StDoorOpen;
          enter_open = 1'b1;
        end else if (timer_q == CloseLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pending latch: a call at the floor whose door is already open is absorbed by the door logic,
  // and the arrival floor is cleared on entry to DoorOpen (clear beats a same-cycle set).
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (req[i] && !(door_state && (i == int'(floor_q)))) begin
        pending_d[i] = 1'b1;
      end
      if (enter_open && (i == int'(floor_d))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Display encoding from the registered state, giving one cycle of latency on the bus.
  logic [3:0] dir_nib;
  logic [3:0] door_nib;
  logic [3:0] tgt_nib;
  logic [3:0] tgt_above;
  logic [3:0] tgt_below;

  always_comb begin
    tgt_above = NibBlank;
    tgt_below = NibBlank;
    // Descending scan: last hit is the lowest pending floor above.
    for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
      if (pending_q[i] && (i > int'(floor_q))) begin
        tgt_above = 4'(i + 1);
      end
    end
    // Ascending scan: last hit is the highest pending floor below.
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (pending_q[i] && (i < int'(floor_q))) begin
        tgt_below = 4'(i + 1);
      end
    end

    dir_nib  = NibDash;
    door_nib = NibDash;
    tgt_nib  = NibBlank;
    case (state_q)
      StMoveUp: begin
        dir_nib = NibUp;
        tgt_nib = tgt_above;
      end
      StMoveDown: begin
        dir_nib = NibDown;
        tgt_nib = tgt_below;
      end
      StDoorOpen:  door_nib = NibOpen;
      StDoorClose: door_nib = NibClose;
      default: ;
    endcase

    bus_d = {tgt_nib, door_nib, dir_nib, floor_q + 4'd1};
  end

  always_ff @(posedge clk190hz or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      floor_q   <= '0;
      timer_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      bus_q     <= BusReset;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      timer_q   <= timer_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      bus_q     <= bus_d;
    end
  end

  assign dataBus   = bus_q;
  assign floor     = floor_q;
  assign pending   = pending_q;
  assign door_open = door_state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// ----------------------------------------------------------------------------------------------
// tb_elevator_ctrl
//
// Self-checking bench for elevator_ctrl (FLOORS=8, MOVE=4, DOOR=8, CLOSE=4). Every cycle the DUT
// outputs are compared with a behavioural model of the controller rules; a table of vectors and
// a few hand-written sequences check fixed expected values for the corner cases.
// ----------------------------------------------------------------------------------------------
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int MT = 4;
  localparam int DT = 8;
  localparam int CT = 4;

  localparam int SIdle  = 0;
  localparam int SUp    = 1;
  localparam int SDn    = 2;
  localparam int SOpen  = 3;
  localparam int SClose = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  req = 8'h00;
  logic        open_btn = 1'b0;
  logic        close_btn = 1'b0;
  logic [15:0] dataBus;
  logic [3:0]  floor;
  logic        door_open;
  logic [7:0]  pending;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int          m_state;
  int          m_floor;
  int          m_timer;
  bit          m_up;
  bit [7:0]    m_pend;
  logic [15:0] m_bus;

  elevator_ctrl #(
    .FLOORS     (NF),
    .MOVE_TICKS (MT),
    .DOOR_TICKS (DT),
    .CLOSE_TICKS(CT)
  ) dut (
    .clk190hz (clk),
    .rst      (rst),
    .req      (req),
    .open_btn (open_btn),
    .close_btn(close_btn),
    .dataBus  (dataBus),
    .floor    (floor),
    .door_open(door_open),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit any_in(bit [7:0] v, int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i < NF && v[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] disp(int s, int f, bit [7:0] p);
    int tgt  = 15;
    int dir  = 12;
    int door = 12;
    if (s == SUp) begin
      dir = 10;
      for (int i = NF - 1; i > f; i--) if (p[i]) tgt = i + 1;
    end
    if (s == SDn) begin
      dir = 11;
      for (int i = 0; i < f; i++) if (p[i]) tgt = i + 1;
    end
    if (s == SOpen)  door = 13;
    if (s == SClose) door = 14;
    return 16'(tgt * 4096 + door * 256 + dir * 16 + f + 1);
  endfunction

  function automatic void model_reset();
    m_state = SIdle;
    m_floor = 0;
    m_timer = 0;
    m_up    = 1'b1;
    m_pend  = '0;
    m_bus   = 16'hFCC1;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  function automatic void model_step(bit [7:0] r, bit o, bit c);
    bit [7:0] all;
    bit [7:0] np;
    int       ns;
    int       nf;
    int       nt;
    bit       nup;
    bit       enter;
    bit       in_door;
    all     = m_pend | r;
    ns      = m_state;
    nf      = m_floor;
    nt      = 0;
    nup     = m_up;
    enter   = 1'b0;
    in_door = (m_state == SOpen) || (m_state == SClose);
    case (m_state)
      SIdle: begin
        if (all[m_floor]) begin
          ns = SOpen; enter = 1'b1;
        end else if (any_in(all, m_floor + 1, NF - 1) &&
                     (m_up || !any_in(all, 0, m_floor - 1))) begin
          ns = SUp; nup = 1'b1;
        end else if (any_in(all, 0, m_floor - 1)) begin
          ns = SDn; nup = 1'b0;
        end
      end
      SUp: begin
        if (m_timer < MT - 1) nt = m_timer + 1;
        else begin
          nf = m_floor + 1;
          if (all[nf]) begin ns = SOpen; enter = 1'b1; end
          else if (!any_in(all, nf + 1, NF - 1)) ns = SIdle;
        end
      end
      SDn: begin
        if (m_timer < MT - 1) nt = m_timer + 1;
        else begin
          nf = m_floor - 1;
          if (all[nf]) begin ns = SOpen; enter = 1'b1; end
          else if (!any_in(all, 0, nf - 1)) ns = SIdle;
        end
      end
      SOpen: begin
        if (o || r[m_floor]) nt = 0;
        else if (c || m_timer == DT - 1) ns = SClose;
        else nt = m_timer + 1;
      end
      default: begin
        if (o || r[m_floor]) begin ns = SOpen; enter = 1'b1; end
        else if (m_timer == CT - 1) ns = SIdle;
        else nt = m_timer + 1;
      end
    endcase
    np = m_pend;
    for (int i = 0; i < NF; i++) begin
      if (r[i] && !(in_door && i == m_floor)) np[i] = 1'b1;
    end
    if (enter) np[nf] = 1'b0;
    m_bus   = disp(m_state, m_floor, m_pend);
    m_state = ns;
    m_floor = nf;
    m_timer = nt;
    m_up    = nup;
    m_pend  = np;
  endfunction

  task automatic step(input logic [7:0] r, input logic o, input logic c);
    req       = r;
    open_btn  = o;
    close_btn = c;
    model_step(r, o, c);
    @(posedge clk);
    #1;
    chk("bus", 32'(dataBus), 32'(m_bus));
    chk("floor", 32'(floor), 32'(m_floor));
    chk("door_open", 32'(door_open), 32'(m_state == SOpen || m_state == SClose));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  // Reset asserted mid-cycle; outputs must respond without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    req       = '0;
    open_btn  = 1'b0;
    close_btn = 1'b0;
    #1;
    chk("rst_bus", 32'(dataBus), 32'h0000FCC1);
    chk("rst_floor", 32'(floor), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  req;
    int          n;
    logic [15:0] bus;
    logic [3:0]  fl;
    logic        dopen;
    logic [7:0]  pend;
  } vec_t;

  vec_t        tbl[9];
  int          cnt;
  int          nd;
  int          maxf;
  bit          found;
  bit          sent;
  logic        prev_door;
  logic [7:0]  r;
  logic [11:0] dseq;
  logic [11:0] tseq;
  logic [7:0]  dirseq;
  logic [3:0]  last_t;
  logic [3:0]  last_d;

  initial begin
    // Single call to floor 4 from floor 1: travel, door open, close, idle.
    tbl[0] = '{8'h08,  1, 16'hFCC1, 4'd0, 1'b0, 8'h08};
    tbl[1] = '{8'h00,  1, 16'h4CA1, 4'd0, 1'b0, 8'h08};
    tbl[2] = '{8'h00, 10, 16'h4CA3, 4'd2, 1'b0, 8'h08};
    tbl[3] = '{8'h00,  1, 16'h4CA3, 4'd3, 1'b1, 8'h00};
    tbl[4] = '{8'h00,  1, 16'hFDC4, 4'd3, 1'b1, 8'h00};
    tbl[5] = '{8'h00,  7, 16'hFDC4, 4'd3, 1'b1, 8'h00};
    tbl[6] = '{8'h00,  1, 16'hFEC4, 4'd3, 1'b1, 8'h00};
    tbl[7] = '{8'h00,  3, 16'hFEC4, 4'd3, 1'b0, 8'h00};
    tbl[8] = '{8'h00,  1, 16'hFCC4, 4'd3, 1'b0, 8'h00};

    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < tbl[k].n; j++) step(tbl[k].req, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_bus", k), 32'(dataBus), 32'(tbl[k].bus));
      chk($sformatf("tbl%0d_floor", k), 32'(floor), 32'(tbl[k].fl));
      chk($sformatf("tbl%0d_door", k), 32'(door_open), 32'(tbl[k].dopen));
      chk($sformatf("tbl%0d_pend", k), 32'(pending), 32'(tbl[k].pend));
    end

    // Door hold with open_btn, then close_btn and re-open from the closing phase.
    do_reset();
    step(8'h01, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      step(8'h00, 1'b1, 1'b0);
      chk("t4_held_open", 32'(door_open), 32'd1);
    end
    cnt   = 0;
    found = 1'b0;
    while (!found && cnt < 40) begin
      step(8'h00, 1'b0, 1'b0);
      cnt++;
      if (dataBus[11:8] == 4'hE) found = 1'b1;
    end
    chk("t4_close_delay", 32'(cnt), 32'(DT + 1));
    step(8'h01, 1'b0, 1'b0);
    chk("t4_reopen", 32'(door_open), 32'd1);
    chk("t4_pend0", 32'(pending[0]), 32'd0);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_open_nib", 32'(dataBus[11:8]), 32'hD);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_close_btn", 32'(dataBus[11:8]), 32'hE);

    // Idle at floor 5, call at the same floor opens the door without moving.
    do_reset();
    step(8'h10, 1'b0, 1'b0);
    found = 1'b0;
    for (int j = 0; j < 200 && !found; j++) begin
      step(8'h00, 1'b0, 1'b0);
      if (dataBus == 16'hFCC5) found = 1'b1;
    end
    chk("t5_reach", 32'(found), 32'd1);
    step(8'h10, 1'b0, 1'b0);
    chk("t5_door", 32'(door_open), 32'd1);
    chk("t5_floor", 32'(floor), 32'd4);
    step(8'h00, 1'b0, 1'b0);
    chk("t5_dir", 32'(dataBus[7:4]), 32'hC);
    chk("t5_door_nib", 32'(dataBus[11:8]), 32'hD);

    // SCAN order: stops at 3 and 6 going up, then reverses for the call placed at 2.
    do_reset();
    step(8'h24, 1'b0, 1'b0);
    nd     = 0;
    dseq   = '0;
    tseq   = '0;
    dirseq = '0;
    last_t = 4'h0;
    last_d = 4'h0;
    sent   = 1'b0;
    for (cnt = 0; cnt < 400 && nd < 3; cnt++) begin
      r = 8'h00;
      if (!sent && floor == 4'd2) begin
        r    = 8'h02;
        sent = 1'b1;
      end
      prev_door = door_open;
      step(r, 1'b0, 1'b0);
      if (door_open && !prev_door) begin
        dseq = {dseq[7:0], floor};
        nd++;
      end
      if (dataBus[7:4] != 4'hC) begin
        if (dataBus[15:12] != last_t) begin
          tseq   = {tseq[7:0], dataBus[15:12]};
          last_t = dataBus[15:12];
        end
        if (dataBus[7:4] != last_d) begin
          dirseq = {dirseq[3:0], dataBus[7:4]};
          last_d = dataBus[7:4];
        end
      end
    end
    chk("t3_stops", 32'(nd), 32'd3);
    chk("t3_stop_floors", 32'(dseq), 32'h251);
    chk("t3_targets", 32'(tseq), 32'h362);
    chk("t3_dirs", 32'(dirseq), 32'hAB);

    // Top floor: never goes past index 7, then travels all the way down.
    do_reset();
    step(8'h80, 1'b0, 1'b0);
    found = 1'b0;
    for (int j = 0; j < 300 && !found; j++) begin
      step(8'h00, 1'b0, 1'b0);
      if (dataBus == 16'hFCC8) found = 1'b1;
    end
    chk("t6_reach_top", 32'(found), 32'd1);
    step(8'h81, 1'b0, 1'b0);
    chk("t6_top_door", 32'(door_open), 32'd1);
    maxf  = 0;
    found = 1'b0;
    for (int j = 0; j < 300 && !found; j++) begin
      step(8'h00, 1'b0, 1'b0);
      if (int'(floor) > maxf) maxf = int'(floor);
      if (door_open && floor == 4'd0) found = 1'b1;
    end
    chk("t6_reach_bottom", 32'(found), 32'd1);
    chk("t6_max_floor", 32'(maxf), 32'd7);

    // Random traffic against the model.
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      for (int b = 0; b < NF; b++) r[b] = ($urandom_range(0, 39) == 0);
      step(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of activity.
    do_reset();
    step(8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
